// File: rtl/fineps_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fineps_pkg: shared types, default constants and saturating clamp    |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package fineps_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PULSE    = 3'd1,
    ST_GUARD    = 3'd2,
    ST_WAIT_RDY = 3'd3,
    ST_DONE     = 3'd4,
    ST_ERROR    = 3'd5
  } state_e;

  localparam int c_DEF_POS_LIMIT      = 1120;
  localparam int c_DEF_GUARD_CYCLES   = 4;
  localparam int c_DEF_TIMEOUT_CYCLES = 1024;

  typedef struct packed {
    logic signed [31:0] value;
    logic               clamped;
  } clamp_t;

  function automatic clamp_t sat_clamp(input logic signed [31:0] value,
                                       input logic signed [31:0] limit);
    clamp_t res;
    res.value   = value;
    res.clamped = 1'b0;
    if (value > limit) begin
      res.value   = limit;
      res.clamped = 1'b1;
    end else if (value < -limit) begin
      res.value   = -limit;
      res.clamped = 1'b1;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fineps_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fineps_sequencer: walks the fine phase-shift position to a target,  |
// | one dready-paced incr/decr pulse at a time.  Revision: 1.0          |
// +--------------------------------------------------------------------+
module fineps_sequencer
  import fineps_pkg::*;
#(
  parameter int INT_POS_WIDTH      = 16,
  parameter int INT_POS_LIMIT      = c_DEF_POS_LIMIT,
  parameter int INT_GUARD_CYCLES   = c_DEF_GUARD_CYCLES,
  parameter int INT_TIMEOUT_CYCLES = c_DEF_TIMEOUT_CYCLES
) (
  input  logic                     in_clk,
  input  logic                     in_rst_n,
  input  logic                     in_cmd_valid,
  output logic                     out_cmd_ready,
  input  logic                     in_cmd_rel,
  input  logic [INT_POS_WIDTH-1:0] in_cmd_value,
  input  logic                     in_fineps_dready,
  output logic                     out_fineps_incr,
  output logic                     out_fineps_decr,
  output logic                     out_fineps_valid,
  output logic [INT_POS_WIDTH-1:0] out_position,
  output logic                     out_busy,
  output logic                     out_done,
  output logic                     out_clamped,
  output logic                     out_error
);

  localparam int CNT_W = $clog2(INT_TIMEOUT_CYCLES + 1);

  state_e                          state_q;
  logic signed [INT_POS_WIDTH-1:0] pos_q;
  logic signed [INT_POS_WIDTH-1:0] target_q;
  logic [CNT_W-1:0]                cnt_q;
  logic                            incr_q;
  logic                            decr_q;
  logic                            valid_q;
  logic                            done_q;
  logic                            clamped_q;
  logic                            error_q;

  logic [INT_POS_WIDTH:0]          sum_d;
  logic signed [31:0]              sum32_d;
  logic signed [31:0]              pos32_d;
  clamp_t                          clamp_d;

  // One extra bit keeps a relative overflow visible so it clamps instead of wrapping.
  always_comb begin
    sum_d = {in_cmd_value[INT_POS_WIDTH-1], in_cmd_value};
    if (in_cmd_rel) begin
      sum_d = sum_d + {pos_q[INT_POS_WIDTH-1], pos_q};
    end
  end

  assign sum32_d = {{(31 - INT_POS_WIDTH){sum_d[INT_POS_WIDTH]}}, sum_d};
  assign pos32_d = {{(32 - INT_POS_WIDTH){pos_q[INT_POS_WIDTH-1]}}, pos_q};
  assign clamp_d = sat_clamp(sum32_d, 32'(INT_POS_LIMIT));

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q   <= ST_IDLE;
      pos_q     <= '0;
      target_q  <= '0;
      cnt_q     <= '0;
      incr_q    <= 1'b0;
      decr_q    <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      clamped_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      valid_q <= 1'b1;
      incr_q  <= 1'b0;
      decr_q  <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_cmd_valid) begin
            target_q  <= clamp_d.value[INT_POS_WIDTH-1:0];
            clamped_q <= clamp_d.clamped;
            if ($signed(clamp_d.value) == pos32_d) begin
              state_q <= ST_DONE;
            end else if (in_fineps_dready) begin
              state_q <= ST_PULSE;
              if ($signed(clamp_d.value) > pos32_d) begin
                incr_q <= 1'b1;
                pos_q  <= pos_q + INT_POS_WIDTH'(1);
              end else begin
                decr_q <= 1'b1;
                pos_q  <= pos_q - INT_POS_WIDTH'(1);
              end
            end else begin
              state_q <= ST_WAIT_RDY;
              cnt_q   <= '0;
            end
          end
        end
        ST_PULSE: begin
          state_q <= ST_GUARD;
          cnt_q   <= '0;
        end
        ST_GUARD: begin
          if (cnt_q == CNT_W'(INT_GUARD_CYCLES - 1)) begin
            state_q <= ST_WAIT_RDY;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_RDY: begin
          if (in_fineps_dready) begin
            if (pos_q == target_q) begin
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_PULSE;
              if (target_q > pos_q) begin
                incr_q <= 1'b1;
                pos_q  <= pos_q + INT_POS_WIDTH'(1);
              end else begin
                decr_q <= 1'b1;
                pos_q  <= pos_q - INT_POS_WIDTH'(1);
              end
            end
          end else if (cnt_q == CNT_W'(INT_TIMEOUT_CYCLES - 1)) begin
            state_q <= ST_ERROR;
            error_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        ST_ERROR: begin
          state_q <= ST_ERROR;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_cmd_ready    = (state_q == ST_IDLE);
  assign out_busy         = (state_q != ST_IDLE);
  assign out_fineps_incr  = incr_q;
  assign out_fineps_decr  = decr_q;
  assign out_fineps_valid = valid_q;
  assign out_position     = pos_q;
  assign out_done         = done_q;
  assign out_clamped      = clamped_q;
  assign out_error        = error_q;

endmodule
`default_nettype wire

// File: tb/tb_fineps_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fineps_sequencer: random commands vs. a step-list reference model |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_fineps_sequencer;

  localparam int W   = 16;
  localparam int LIM = 1120;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_cmd_valid = 1'b0;
  logic         in_cmd_rel = 1'b0;
  logic [W-1:0] in_cmd_value = '0;
  logic         in_fineps_dready = 1'b1;
  logic         out_cmd_ready;
  logic         out_fineps_incr;
  logic         out_fineps_decr;
  logic         out_fineps_valid;
  logic [W-1:0] out_position;
  logic         out_busy;
  logic         out_done;
  logic         out_clamped;
  logic         out_error;

  fineps_sequencer #(
    .INT_POS_WIDTH     (W),
    .INT_POS_LIMIT     (LIM),
    .INT_GUARD_CYCLES  (4),
    .INT_TIMEOUT_CYCLES(1024)
  ) dut (
    .in_clk          (clk),
    .in_rst_n        (rst_n),
    .in_cmd_valid    (in_cmd_valid),
    .out_cmd_ready   (out_cmd_ready),
    .in_cmd_rel      (in_cmd_rel),
    .in_cmd_value    (in_cmd_value),
    .in_fineps_dready(in_fineps_dready),
    .out_fineps_incr (out_fineps_incr),
    .out_fineps_decr (out_fineps_decr),
    .out_fineps_valid(out_fineps_valid),
    .out_position    (out_position),
    .out_busy        (out_busy),
    .out_done        (out_done),
    .out_clamped     (out_clamped),
    .out_error       (out_error)
  );

  always #5 clk = ~clk;

  // kind: 0 = incr pulse, 1 = decr pulse, 2 = done; at = required cycle or -1
  typedef struct {
    int kind;
    int pos;
    int clamped;
    int at;
  } item_t;

  item_t sbq[$];
  item_t mit;
  int    mk;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    mpos = 0;
  int    last_pulse = -100;
  int    pulses_seen = 0;
  int    drop_len = 0;
  int    lowcnt = 0;
  bit    rnd_rdy = 1'b0;
  bit    force_low = 1'b0;
  bit    kill_on_pulse = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Synthesizer stand-in: dready drops for drop_len cycles after each pulse.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      lowcnt           = 0;
      in_fineps_dready = 1'b1;
    end else begin
      if (out_fineps_incr || out_fineps_decr) begin
        lowcnt = drop_len;
        if (kill_on_pulse) force_low = 1'b1;
      end
      if (force_low) begin
        in_fineps_dready = 1'b0;
      end else if (lowcnt > 0) begin
        in_fineps_dready = 1'b0;
        lowcnt--;
      end else begin
        in_fineps_dready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_fineps_incr && out_fineps_decr) check("incr_decr_exclusive", 1, 0);
      if (out_fineps_incr || out_fineps_decr || out_done) begin
        mk = out_fineps_incr ? 0 : (out_fineps_decr ? 1 : 2);
        if (sbq.size() == 0) begin
          check("unexpected_output_kind", mk, -1);
        end else begin
          mit = sbq.pop_front();
          check("output_kind", mk, mit.kind);
          check("position", $signed(out_position), mit.pos);
          if (mk == 2) check("clamped", out_clamped, mit.clamped);
          if (mit.at >= 0) check("latency_cycle", cyc, mit.at);
        end
        if (mk != 2) begin
          check("pulse_spacing_ge6", (cyc - last_pulse) >= 6, 1);
          last_pulse = cyc;
          pulses_seen++;
        end
      end
    end
  end

  task automatic send_cmd(input bit rel, input int val);
    int t, cl, n, dir, w;
    w = 0;
    @(negedge clk);
    while (!out_cmd_ready && w < 60000) begin
      @(negedge clk);
      w++;
    end
    if (!out_cmd_ready) begin
      check("cmd_ready_wait", 0, 1);
      return;
    end
    t  = rel ? mpos + val : val;
    cl = 0;
    if (t > LIM) begin
      t  = LIM;
      cl = 1;
    end else if (t < -LIM) begin
      t  = -LIM;
      cl = 1;
    end
    n   = (t > mpos) ? t - mpos : mpos - t;
    dir = (t > mpos) ? 0 : 1;
    for (int i = 1; i <= n; i++) begin
      sbq.push_back('{dir, (dir == 0) ? mpos + i : mpos - i, 0,
                      (i == 1 && in_fineps_dready) ? cyc + 1 : -1});
    end
    sbq.push_back('{2, t, cl, (n == 0) ? cyc + 2 : -1});
    mpos         = t;
    pulses_seen  = 0;
    in_cmd_valid = 1'b1;
    in_cmd_rel   = rel;
    in_cmd_value = W'(val);
    @(negedge clk);
    in_cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while ((sbq.size() != 0 || out_busy) && w < limit);
    check("move_completes", (sbq.size() == 0 && !out_busy), 1);
  endtask

  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_incr", out_fineps_incr, 0);
    check("rst_decr", out_fineps_decr, 0);
    check("rst_valid", out_fineps_valid, 0);
    check("rst_done", out_done, 0);
    check("rst_clamped", out_clamped, 0);
    check("rst_error", out_error, 0);
    check("rst_position", $signed(out_position), 0);
    check("rst_busy", out_busy, 0);
    check("rst_ready", out_cmd_ready, 1);
    sbq.delete();
    mpos          = 0;
    force_low     = 1'b0;
    kill_on_pulse = 1'b0;
    last_pulse    = -100;
    in_cmd_valid  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("valid_after_release", out_fineps_valid, 1);
  endtask

  initial begin
    int w;
    apply_reset();

    send_cmd(1'b0, 0);
    wait_idle(100);

    drop_len = 10;
    send_cmd(1'b0, 5);
    wait_idle(2000);
    check("pos_abs5", $signed(out_position), 5);
    check("busy_after_abs5", out_busy, 0);

    send_cmd(1'b1, -8);
    repeat (3) @(negedge clk);
    check("ready_low_while_busy", out_cmd_ready, 0);
    in_cmd_valid = 1'b1;
    in_cmd_rel   = 1'b0;
    in_cmd_value = W'(77);
    repeat (4) @(negedge clk);
    in_cmd_valid = 1'b0;
    wait_idle(2000);
    check("pos_rel_m8", $signed(out_position), -3);

    for (int i = 0; i < 10; i++) begin
      drop_len = $urandom_range(0, 12);
      rnd_rdy  = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 1) send_cmd(1'b1, int'($urandom_range(0, 80)) - 40);
      else                           send_cmd(1'b0, int'($urandom_range(0, 120)) - 60);
      wait_idle(20000);
      check("pos_random", $signed(out_position), mpos);
    end
    rnd_rdy  = 1'b0;
    drop_len = 0;

    send_cmd(1'b1, 20);
    w = 0;
    while (!(pulses_seen == 6 && out_fineps_incr) && w < 1000) begin
      @(posedge clk);
      #2;
      w++;
    end
    check("reached_step7", (pulses_seen == 6 && out_fineps_incr), 1);
    apply_reset();

    send_cmd(1'b0, 2000);
    wait_idle(20000);
    check("pos_clamp_pos", $signed(out_position), 1120);
    check("clamped_sticky", out_clamped, 1);

    send_cmd(1'b1, 32767);
    wait_idle(100);
    check("pos_rel_overflow", $signed(out_position), 1120);

    send_cmd(1'b0, -32768);
    wait_idle(30000);
    check("pos_clamp_neg", $signed(out_position), -1120);

    kill_on_pulse = 1'b1;
    send_cmd(1'b1, 3);
    w = 0;
    while (!out_error && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("error_delay", cyc - last_pulse, 1029);
    sbq.delete();
    in_cmd_valid = 1'b1;
    in_cmd_rel   = 1'b0;
    in_cmd_value = W'(0);
    repeat (100) @(negedge clk);
    in_cmd_valid = 1'b0;
    check("error_ready", out_cmd_ready, 0);
    check("error_busy", out_busy, 1);
    check("error_sticky", out_error, 1);
    apply_reset();

    send_cmd(1'b0, 4);
    wait_idle(2000);
    check("pos_after_error_reset", $signed(out_position), 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
`default_nettype wire
